// File: rtl/mux_4to1_rr_sched_if.sv
// Handshake/bus bundle for mux_4to1_rr_sched: producer-side valid/ready, mux data/select, downstream valid/ready.
interface mux_4to1_rr_sched_if #(
  parameter int unsigned WIDTH = 4
);
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic [WIDTH-1:0]   d;
  logic [1:0]         sel;
  logic               o_valid;
  logic               o_ready;

  modport master (
    output in_data, in_valid, o_ready,
    input  in_ready, a, b, c, d, sel, o_valid
  );

  modport slave (
    input  in_data, in_valid, o_ready,
    output in_ready, a, b, c, d, sel, o_valid
  );
endinterface

// File: rtl/mux_4to1_rr_sched.sv
// Sequencer feeding a combinational 4:1 mux: per-channel holding slots, round-robin grant, valid/ready out.
// Define MUX_SCHED_FIXED_PRIO_EN to replace round-robin with fixed priority (channel 0 highest).
module mux_4to1_rr_sched #(
  parameter int unsigned WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  mux_4to1_rr_sched_if.slave bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       full_q, full_d;
  logic [WIDTH-1:0] slot_q [4];
  logic [WIDTH-1:0] slot_d [4];
  logic [1:0]       sel_q, sel_d;
  logic             o_valid_q, o_valid_d;
  logic [3:0]       in_ready;
  logic [3:0]       loads;
  logic [3:0]       clears;
  logic             xfer;
  logic [1:0]       pick_idle;
  logic [1:0]       pick_next;

`ifdef MUX_SCHED_FIXED_PRIO_EN
  function automatic logic [1:0] prio_pick(input logic [3:0] v);
    logic [1:0] idx;
    prio_pick = '0;
    // Scan high to low so the lowest set index is the last one written.
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = 2'(k - 1);
      if (v[idx]) prio_pick = idx;
    end
  endfunction

  always_comb begin
    pick_idle = prio_pick(full_q);
    pick_next = prio_pick(full_d);
  end
`else
  logic [1:0] last_grant_q, last_grant_d;

  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    // Scan base+4 down to base+1 so the first set bit after base is the last one written.
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (v[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    pick_idle    = rr_pick(full_q, last_grant_q);
    pick_next    = rr_pick(full_d, sel_q);
    last_grant_d = xfer ? sel_q : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 2'd3;
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    in_ready = rst ? '0 : ~full_q;
    loads    = bus.in_valid & in_ready;
    xfer     = o_valid_q & bus.o_ready;
    clears   = xfer ? (4'b0001 << sel_q) : '0;
    full_d   = (full_q | loads) & ~clears;
    for (int unsigned i = 0; i < 4; i++) begin
      slot_d[i] = loads[i] ? bus.in_data[i*WIDTH +: WIDTH] : slot_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    o_valid_d = o_valid_q;
    case (state_q)
      IDLE: begin
        o_valid_d = 1'b0;
        if (|full_q) begin
          sel_d     = pick_idle;
          o_valid_d = 1'b1;
          state_d   = PRESENT;
        end
      end
      PRESENT: begin
        o_valid_d = 1'b1;
        if (bus.o_ready) begin
          // Loads landing in the transfer cycle are already in full_d, so they compete here.
          if (|full_d) begin
            sel_d = pick_next;
          end else begin
            o_valid_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        o_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      full_q    <= '0;
      slot_q    <= '{default: '0};
      sel_q     <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      slot_q    <= slot_d;
      sel_q     <= sel_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.a        = slot_q[0];
  assign bus.b        = slot_q[1];
  assign bus.c        = slot_q[2];
  assign bus.d        = slot_q[3];
  assign bus.sel      = sel_q;
  assign bus.o_valid  = o_valid_q;

endmodule
